// File: rtl/cei_addr_decode_pipe_if.sv
// rtl/cei_addr_decode_pipe_if.sv - request/decode handshake bundle for the address decoder
interface cei_addr_decode_pipe_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 3
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  dec_valid_o;
  logic                  dec_ready_i;
  logic [ADDR_WIDTH-1:0] dec_addr_o;
  logic [IDX_WIDTH-1:0]  dec_idx_o;
  logic                  dec_miss_o;
  logic                  dec_multi_o;

  // Decoder side: consumes requests, produces decode results.
  modport slave (
    input  req_valid_i, req_addr_i, dec_ready_i,
    output req_ready_o, dec_valid_o, dec_addr_o, dec_idx_o, dec_miss_o, dec_multi_o
  );

  // Crossbar side: issues requests, consumes decode results.
  modport master (
    output req_valid_i, req_addr_i, dec_ready_i,
    input  req_ready_o, dec_valid_o, dec_addr_o, dec_idx_o, dec_miss_o, dec_multi_o
  );
endinterface

// File: rtl/cei_addr_decode_pipe.sv
// rtl/cei_addr_decode_pipe.sv - programmable rule-table address decoder with one registered stage
module cei_addr_decode_pipe #(
  parameter int NUM_RULES   = 6,
  parameter int ADDR_WIDTH  = 32,
  parameter int IDX_WIDTH   = 3,
  parameter int DEFAULT_IDX = 0,
  localparam int RULE_SEL_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [RULE_SEL_W-1:0] cfg_rule_i,
  input  logic [1:0]            cfg_field_i,
  input  logic [ADDR_WIDTH-1:0] cfg_wdata_i,
  output logic                  cfg_err_o,
  output logic                  lock_o,
  output logic [15:0]           miss_count_o,
  cei_addr_decode_pipe_if.slave bus
);

  localparam logic [RULE_SEL_W:0] NUM_RULES_W = (RULE_SEL_W+1)'(NUM_RULES);

  logic [ADDR_WIDTH-1:0] rule_start [NUM_RULES];
  logic [ADDR_WIDTH-1:0] rule_end   [NUM_RULES];
  logic [IDX_WIDTH-1:0]  rule_idx   [NUM_RULES];
  logic                  rule_en    [NUM_RULES];

  logic                 cfg_rule_ok;
  logic                 cfg_wr_ok;
  logic                 dec_hit;
  logic                 dec_multi;
  logic [IDX_WIDTH-1:0] dec_idx;
  logic                 accept;

  // A write is rejected if it targets a missing slot or the table is locked.
  assign cfg_rule_ok = ({1'b0, cfg_rule_i} < NUM_RULES_W);
  assign cfg_wr_ok   = cfg_we_i && cfg_rule_ok && !lock_o;

  // Rule table, lock flag and registered reject pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_RULES; r++) begin
        rule_start[r] <= '0;
        rule_end[r]   <= '0;
        rule_idx[r]   <= '0;
        rule_en[r]    <= 1'b0;
      end
      lock_o    <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      cfg_err_o <= cfg_we_i && (lock_o || !cfg_rule_ok);
      if (cfg_wr_ok) begin
        for (int r = 0; r < NUM_RULES; r++) begin
          if (cfg_rule_i == RULE_SEL_W'(r)) begin
            case (cfg_field_i)
              2'd0: rule_start[r] <= cfg_wdata_i;
              2'd1: rule_end[r]   <= cfg_wdata_i;
              2'd2: begin
                rule_en[r]  <= cfg_wdata_i[IDX_WIDTH];
                rule_idx[r] <= cfg_wdata_i[IDX_WIDTH-1:0];
              end
              default: if (cfg_wdata_i[0]) lock_o <= 1'b1;
            endcase
          end
        end
      end
    end
  end

  // Match the incoming address against every rule; lowest-numbered hit wins.
  always_comb begin
    dec_hit   = 1'b0;
    dec_multi = 1'b0;
    dec_idx   = IDX_WIDTH'(DEFAULT_IDX);
    for (int r = 0; r < NUM_RULES; r++) begin
      if (rule_en[r] && (bus.req_addr_i >= rule_start[r]) && (bus.req_addr_i < rule_end[r])) begin
        if (dec_hit) begin
          dec_multi = 1'b1;
        end else begin
          dec_hit = 1'b1;
          dec_idx = rule_idx[r];
        end
      end
    end
  end

  assign bus.req_ready_o = !bus.dec_valid_o || bus.dec_ready_i;
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  // Output stage: capture on handshake, drop when consumed, count accepted misses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.dec_valid_o <= 1'b0;
      bus.dec_addr_o  <= '0;
      bus.dec_idx_o   <= '0;
      bus.dec_miss_o  <= 1'b0;
      bus.dec_multi_o <= 1'b0;
      miss_count_o    <= '0;
    end else if (accept) begin
      bus.dec_valid_o <= 1'b1;
      bus.dec_addr_o  <= bus.req_addr_i;
      bus.dec_idx_o   <= dec_idx;
      bus.dec_miss_o  <= !dec_hit;
      bus.dec_multi_o <= dec_multi;
      if (!dec_hit && (miss_count_o != 16'hFFFF)) begin
        miss_count_o <= miss_count_o + 16'd1;
      end
    end else if (bus.dec_ready_i) begin
      bus.dec_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/cei_addr_decode_pipe.md
# cei_addr_decode_pipe

Runtime-programmable, pipelined address decoder for the system and per-CPU crossbars. It replaces the fixed compile-time rule tables with `NUM_RULES` register-backed rules that software programs through a configuration port. Decode is registered behind a valid/ready stage. The block reports misses and overlapping rules, keeps a saturating miss counter, and supports a one-way lock that freezes the table until reset.

## Interface
- `NUM_RULES`, 6, number of rule slots (≥1).
- `ADDR_WIDTH`, 32, address and rule bound width.
- `IDX_WIDTH`, 3, width of the target port index.
- `DEFAULT_IDX`, 0, index returned on a miss (error slave).
- `RULE_SEL_W`, `$clog2(NUM_RULES)` (min 1), rule select width; derived, not overridden.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high, single clock domain.
- `cfg_we_i` in 1: configuration write strobe.
- `cfg_rule_i` in RULE_SEL_W: rule slot to write.
- `cfg_field_i` in 2: target field. 0 = start, 1 = end, 2 = {enable, idx}, 3 = lock.
- `cfg_wdata_i` in ADDR_WIDTH: write data. Field 2 uses `[IDX_WIDTH]` = enable and `[IDX_WIDTH-1:0]` = idx. Field 3 uses `[0]`.
- `cfg_err_o` out 1: one-cycle pulse for a rejected write.
- `lock_o` out 1: table locked.
- `req_valid_i` in 1: request address valid.
- `req_ready_o` out 1: stage can accept.
- `req_addr_i` in ADDR_WIDTH: address to decode.
- `dec_valid_o` out 1: decode result valid.
- `dec_ready_i` in 1: consumer accepts the result.
- `dec_addr_o` out ADDR_WIDTH: registered copy of the address.
- `dec_idx_o` out IDX_WIDTH: selected port index.
- `dec_miss_o` out 1: no enabled rule matched.
- `dec_multi_o` out 1: more than one enabled rule matched.
- `miss_count_o` out 16: saturating count of accepted misses.

## Operation
- Rule r matches when enable_r = 1 and start_r ≤ addr < end_r. Comparison is unsigned and end is exclusive, i.e. end = start + size.
- A rule with start ≥ end never matches.
- Priority: the lowest-numbered matching rule wins.
- `dec_multi_o` = 1 when ≥2 rules match. The winner is still the lowest-numbered one.
- On a miss: `dec_idx_o` = DEFAULT_IDX and `dec_miss_o` = 1.
- Decode is combinational on `req_addr_i` against the current table. The result is captured into the output register on handshake (`req_valid_i && req_ready_o`).
- `req_ready_o` = !dec_valid_o || dec_ready_i, giving a single stage with full throughput.
- Config writes update the addressed field at the clock edge.
  - A write with `cfg_rule_i` ≥ NUM_RULES is ignored and pulses `cfg_err_o`.
  - Field 3 with `wdata[0]` = 1 sets lock. Field 3 with `wdata[0]` = 0 is a no-op with no error.
- While locked, every config write is ignored and pulses `cfg_err_o`. Lock clears only on reset.
- `miss_count_o` increments on each accepted miss and holds at 0xFFFF.

## Timing
- Reset values:
  - All rules: start = 0, end = 0, idx = 0, enable = 0.
  - `lock_o` = 0, `dec_valid_o` = 0, `dec_addr_o` = 0, `dec_idx_o` = 0, `dec_miss_o` = 0, `dec_multi_o` = 0, `miss_count_o` = 0, `cfg_err_o` = 0.
  - `req_ready_o` = 1.
- Reset mid-operation drops any held result; there is no partial state.
- Latency: result visible the cycle after acceptance.
- Output hold: while `dec_valid_o` = 1 and `dec_ready_i` = 0, all `dec_*` outputs are stable and `req_ready_o` = 0.
- Simultaneous pop and push: when `dec_ready_i` = 1 and a new request is accepted in the same cycle, the new result replaces the old one next cycle and `dec_valid_o` stays 1.
- Config write in the same cycle as an accepted request: the request is decoded with the old table. The new value applies from the next cycle.
- Lock write and a second write cannot happen in the same cycle (single port). Writes in the cycle after the lock write are rejected.
- `cfg_err_o` is registered: it asserts the cycle after the rejected write, for one cycle per rejected write.
- `miss_count_o` updates the cycle after acceptance, coincident with the `dec_valid_o` that carries the miss.

## Test plan
- Reset, then request `0xF0020010` with no rules programmed -> next cycle: `dec_valid_o` = 1, `dec_idx_o` = 0, `dec_miss_o` = 1, `miss_count_o` = 1.
- Program rule 3 = [`0xF0020000`, `0xF0028000`), idx 3, enabled. Requests `0xF0020000`, `0xF0027FFC`, `0xF0028000` back-to-back with `dec_ready_i` = 1 -> idx 3, idx 3, then miss. One result per cycle, `req_ready_o` stays 1.
- Rule 0 = [`0x0`, `0x41000000`) idx 2, rule 1 = [`0x10000000`, `0x10001000`) idx 1. Request `0x10000004` -> `dec_idx_o` = 2, `dec_multi_o` = 1.
- Hold `dec_ready_i` = 0 for 3 cycles with a result pending -> `req_ready_o` = 0 and outputs unchanged for those 3 cycles. Raise `dec_ready_i` together with a new request -> the new result appears next cycle.
- Write lock, then write rule 0 start = `0x1234` -> `cfg_err_o` pulses for 1 cycle and rule 0 is unchanged. Also write `cfg_rule_i` = 7 with NUM_RULES = 6 before locking -> `cfg_err_o` pulses.
- Force 65537 accepted misses -> `miss_count_o` = `0xFFFF`. Assert `rst_i` for 1 cycle mid-stream -> all outputs return to their reset values the next cycle.
